// File: rtl/elastic_pkg.sv
// Shared definitions for the elastic dataflow operator: operation codes,
// the name-to-code mapping used at elaboration time, and the operand limit.
package elastic_pkg;

   localparam int MAX_INPUTS = 3;

   typedef enum logic [3:0] {
      OP_REG,
      OP_IN,
      OP_OUT,
      OP_ADDI,
      OP_SUBI,
      OP_MULI,
      OP_ADD,
      OP_SUB,
      OP_MUL,
      OP_AND,
      OP_OR,
      OP_XOR
   } op_e;

   // Operation names arrive as packed strings of up to five characters.
   // An unknown name falls back to a plain pass-through register.
   function automatic op_e op_from_name(input logic [39:0] name);
      op_e code;
      code = OP_REG;
      case (name)
         40'("reg"):  code = OP_REG;
         40'("in"):   code = OP_IN;
         40'("out"):  code = OP_OUT;
         40'("addi"): code = OP_ADDI;
         40'("subi"): code = OP_SUBI;
         40'("muli"): code = OP_MULI;
         40'("add"):  code = OP_ADD;
         40'("sub"):  code = OP_SUB;
         40'("mul"):  code = OP_MUL;
         40'("and"):  code = OP_AND;
         40'("or"):   code = OP_OR;
         40'("xor"):  code = OP_XOR;
         default:     code = OP_REG;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/elastic_op_alu.sv
// Combinational operator core. Immediate ops combine slot 0 with the
// constant; binary ops fold left across all operand slots. Results wrap
// modulo 2^DATA_WIDTH.
module elastic_op_alu
   import elastic_pkg::*;
#(
   parameter int                  DATA_WIDTH = 32,
   parameter int                  INPUT_SIZE = 1,
   parameter op_e                 OP_CODE    = OP_REG,
   parameter logic [DATA_WIDTH-1:0] IMMEDIATE = '0
) (
   input  logic [DATA_WIDTH*INPUT_SIZE-1:0] operands,
   output logic [DATA_WIDTH-1:0]            result
);

   function automatic logic [DATA_WIDTH-1:0] combine(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH-1:0] r;
      case (OP_CODE)
         OP_ADD, OP_ADDI: r = a + b;
         OP_SUB, OP_SUBI: r = a - b;
         OP_MUL, OP_MULI: r = a * b;
         OP_AND:          r = a & b;
         OP_OR:           r = a | b;
         OP_XOR:          r = a ^ b;
         default:         r = a;
      endcase
      return r;
   endfunction

   // Immediate forms use slot 0 only; everything else folds ((s0 op s1) op s2)
   always_comb begin
      result = operands[DATA_WIDTH-1:0];
      if (OP_CODE == OP_ADDI || OP_CODE == OP_SUBI || OP_CODE == OP_MULI) begin
         result = combine(operands[DATA_WIDTH-1:0], IMMEDIATE);
      end else begin
         for (int i = 1; i < INPUT_SIZE; i++) begin
            result = combine(result, operands[i*DATA_WIDTH +: DATA_WIDTH]);
         end
      end
   end

endmodule

// File: rtl/elastic_operator.sv
// Buffered dataflow node: gathers one token per input slot, pushes the
// operator result into a small FIFO and serves every fork output exactly
// once per token before popping the head.
module elastic_operator
   import elastic_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    INPUT_SIZE  = 1,
   parameter int                    OUTPUT_SIZE = 1,
   parameter int                    DEPTH       = 2,
   parameter logic [39:0]           OP          = "reg",
   parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0
) (
   input  logic                             clk,
   input  logic                             rst,
   output logic [INPUT_SIZE-1:0]            req_l,
   input  logic [INPUT_SIZE-1:0]            ack_l,
   input  logic [DATA_WIDTH*INPUT_SIZE-1:0] din,
   input  logic [OUTPUT_SIZE-1:0]           req_r,
   output logic [OUTPUT_SIZE-1:0]           ack_r,
   output logic [DATA_WIDTH-1:0]            dout,
   output logic [$clog2(DEPTH+1)-1:0]       level
);

   localparam int  LEVEL_W = $clog2(DEPTH+1);
   localparam int  PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam op_e OP_CODE = op_from_name(OP);
   localparam logic [PTR_W-1:0]   LAST_PTR   = PTR_W'(DEPTH-1);
   localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

   logic                             live;
   logic [INPUT_SIZE-1:0]            has;
   logic [DATA_WIDTH*INPUT_SIZE-1:0] slots;
   logic [DATA_WIDTH-1:0]            result;
   logic [DATA_WIDTH-1:0]            mem [DEPTH];
   logic [PTR_W-1:0]                 wr_ptr;
   logic [PTR_W-1:0]                 rd_ptr;
   logic [OUTPUT_SIZE-1:0]           served;
   logic [OUTPUT_SIZE-1:0]           ack_q;
   logic                             push;
   logic                             pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   elastic_op_alu #(
      .DATA_WIDTH (DATA_WIDTH),
      .INPUT_SIZE (INPUT_SIZE),
      .OP_CODE    (OP_CODE),
      .IMMEDIATE  (IMMEDIATE)
   ) u_alu (
      .operands (slots),
      .result   (result)
   );

   // Requests stay low for one cycle after reset so upstream sees a clean restart
   assign req_l = live ? ~has : '0;
   assign pop   = &served;
   assign push  = (&has) && ((level != FULL_LEVEL) || pop);
   assign dout  = mem[rd_ptr];
   assign ack_r = ack_q;

   // Marks the node as running once reset has been released for an edge
   always_ff @(posedge clk) begin
      if (rst) live <= 1'b0;
      else     live <= 1'b1;
   end

   // Operand slots: capture on an acknowledged request, release on push
   always_ff @(posedge clk) begin
      if (rst) begin
         has <= '0;
      end else begin
         for (int i = 0; i < INPUT_SIZE; i++) begin
            if (push) begin
               has[i] <= 1'b0;
            end else if (ack_l[i] && req_l[i]) begin
               has[i]                             <= 1'b1;
               slots[i*DATA_WIDTH +: DATA_WIDTH] <= din[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   // Result FIFO with wrap-around pointers; occupancy tracks push/pop pairs
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= result;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (pop) rd_ptr <= next_ptr(rd_ptr);
         if (push && !pop)      level <= level + LEVEL_W'(1);
         else if (!push && pop) level <= level - LEVEL_W'(1);
      end
   end

   // Eager fork: each requesting consumer gets one ack per head token
   always_ff @(posedge clk) begin
      if (rst) begin
         served <= '0;
         ack_q  <= '0;
      end else if (pop) begin
         served <= '0;
         ack_q  <= '0;
      end else begin
         for (int j = 0; j < OUTPUT_SIZE; j++) begin
            if (level != '0 && req_r[j] && !served[j] && !ack_q[j]) begin
               ack_q[j]  <= 1'b1;
               served[j] <= 1'b1;
            end else begin
               ack_q[j] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_elastic_operator.sv
// Directed bench for elastic_operator using two instances: an 8-bit
// three-input adder with a three-way fork and a 16-bit addi node with a
// depth-3 FIFO fed by a streaming producer/consumer pair.
module tb_elastic_operator;

   logic clk;
   logic rst;

   logic [2:0]  a_req_l;
   logic [2:0]  a_ack_l;
   logic [23:0] a_din;
   logic [2:0]  a_req_r;
   logic [2:0]  a_ack_r;
   logic [7:0]  a_dout;
   logic [1:0]  a_level;

   logic [0:0]  b_req_l;
   logic [0:0]  b_ack_l;
   logic [15:0] b_din;
   logic [0:0]  b_req_r;
   logic [0:0]  b_ack_r;
   logic [15:0] b_dout;
   logic [1:0]  b_level;

   int checks;
   int errors;
   int sent;
   int recv;
   int got;
   logic [7:0] exp_a [3];

   elastic_operator #(
      .DATA_WIDTH (8), .INPUT_SIZE (3), .OUTPUT_SIZE (3), .DEPTH (2), .OP ("add")
   ) dut_a (
      .clk (clk), .rst (rst),
      .req_l (a_req_l), .ack_l (a_ack_l), .din (a_din),
      .req_r (a_req_r), .ack_r (a_ack_r), .dout (a_dout), .level (a_level)
   );

   elastic_operator #(
      .DATA_WIDTH (16), .INPUT_SIZE (1), .OUTPUT_SIZE (1), .DEPTH (3),
      .OP ("addi"), .IMMEDIATE (16'd2)
   ) dut_b (
      .clk (clk), .rst (rst),
      .req_l (b_req_l), .ack_l (b_ack_l), .din (b_din),
      .req_r (b_req_r), .ack_r (b_ack_r), .dout (b_dout), .level (b_level)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] ackl, input logic [23:0] d, input logic [2:0] reqr);
      a_ack_l = ackl;
      a_din   = d;
      a_req_r = reqr;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Directed sequence covering reset, latency, fold/wrap, backpressure, fork and streaming
   initial begin
      checks = 0;
      errors = 0;
      exp_a  = '{8'd23, 8'd33, 8'd43};
      rst = 1'b1;
      applyStimulus(3'b000, 24'd0, 3'b000);
      b_ack_l = 1'b0; b_din = '0; b_req_r = 1'b0;
      stepClock();
      stepClock();
      rst = 1'b0;
      stepClock();
      checkOutput("reset_req_l", {29'd0, a_req_l}, 32'd7);
      checkOutput("reset_level", {30'd0, a_level}, 32'd0);
      checkOutput("reset_dout", {24'd0, a_dout}, 32'd0);
      checkOutput("reset_ack_r", {29'd0, a_ack_r}, 32'd0);

      // Fold with wrap: ((200 + 100) + 1) mod 256 = 45
      applyStimulus(3'b111, {8'd1, 8'd100, 8'd200}, 3'b111);
      stepClock();
      applyStimulus(3'b000, 24'd0, 3'b111);
      checkOutput("fold_req_l_low", {29'd0, a_req_l}, 32'd0);
      stepClock();
      checkOutput("fold_level", {30'd0, a_level}, 32'd1);
      checkOutput("fold_dout", {24'd0, a_dout}, 32'd45);
      checkOutput("fold_no_ack_yet", {29'd0, a_ack_r}, 32'd0);
      stepClock();
      checkOutput("fold_ack", {29'd0, a_ack_r}, 32'd7);
      checkOutput("fold_dout_ack", {24'd0, a_dout}, 32'd45);
      stepClock();
      checkOutput("fold_popped", {30'd0, a_level}, 32'd0);
      checkOutput("fold_ack_done", {29'd0, a_ack_r}, 32'd0);

      // Backpressure: consumers idle, tokens 6,20,30 (+1+2) offered
      applyStimulus(3'b111, {8'd1, 8'd2, 8'd6}, 3'b000);
      stepClock();
      applyStimulus(3'b000, 24'd0, 3'b000);
      stepClock();
      checkOutput("bp_level1", {30'd0, a_level}, 32'd1);
      applyStimulus(3'b111, {8'd1, 8'd2, 8'd20}, 3'b000);
      stepClock();
      applyStimulus(3'b000, 24'd0, 3'b000);
      stepClock();
      checkOutput("bp_level2", {30'd0, a_level}, 32'd2);
      applyStimulus(3'b111, {8'd1, 8'd2, 8'd30}, 3'b000);
      stepClock();
      applyStimulus(3'b000, 24'd0, 3'b000);
      stepClock();
      checkOutput("bp_full_level", {30'd0, a_level}, 32'd2);
      checkOutput("bp_req_l_held", {29'd0, a_req_l}, 32'd0);
      repeat (3) stepClock();
      checkOutput("bp_still_held", {29'd0, a_req_l}, 32'd0);
      checkOutput("bp_no_ack", {29'd0, a_ack_r}, 32'd0);

      // Uneven fork: consumer 1 waits 10 cycles while 0 and 2 are served once
      applyStimulus(3'b000, 24'd0, 3'b101);
      stepClock();
      checkOutput("fork_ack_02", {29'd0, a_ack_r}, 32'd5);
      checkOutput("fork_head", {24'd0, a_dout}, 32'd9);
      for (int c = 0; c < 10; c++) begin
         stepClock();
         checkOutput("fork_no_reack", {29'd0, a_ack_r}, 32'd0);
         checkOutput("fork_no_pop", {30'd0, a_level}, 32'd2);
      end
      applyStimulus(3'b000, 24'd0, 3'b111);
      stepClock();
      checkOutput("fork_ack_1", {29'd0, a_ack_r}, 32'd2);
      checkOutput("fork_head_1", {24'd0, a_dout}, 32'd9);
      stepClock();
      checkOutput("fork_pop_push_level", {30'd0, a_level}, 32'd2);
      checkOutput("fork_next_head", {24'd0, a_dout}, 32'd23);
      checkOutput("fork_slots_free", {29'd0, a_req_l}, 32'd7);

      // Drain in order while a fourth token enters
      applyStimulus(3'b111, {8'd1, 8'd2, 8'd40}, 3'b111);
      got = 0;
      for (int c = 0; c < 30 && got < 3; c++) begin
         stepClock();
         a_ack_l = 3'b000;
         if (a_ack_r != 3'b000) begin
            checkOutput("drain_ack_all", {29'd0, a_ack_r}, 32'd7);
            checkOutput("drain_order", {24'd0, a_dout}, {24'd0, exp_a[got]});
            got++;
         end
      end
      checkOutput("drain_count", got, 32'd3);
      stepClock();
      checkOutput("drain_empty", {30'd0, a_level}, 32'd0);

      // Basic latency on the addi node: 5 + 2 = 7, ack two edges after ack_l
      b_req_r = 1'b1; b_din = 16'd5; b_ack_l = 1'b1;
      stepClock();
      b_ack_l = 1'b0;
      checkOutput("lat_req_l_low", {31'd0, b_req_l}, 32'd0);
      checkOutput("lat_level0", {30'd0, b_level}, 32'd0);
      checkOutput("lat_no_ack_t", {31'd0, b_ack_r}, 32'd0);
      stepClock();
      checkOutput("lat_level1", {30'd0, b_level}, 32'd1);
      checkOutput("lat_dout", {16'd0, b_dout}, 32'd7);
      checkOutput("lat_no_ack_t1", {31'd0, b_ack_r}, 32'd0);
      stepClock();
      checkOutput("lat_ack_t2", {31'd0, b_ack_r}, 32'd1);
      checkOutput("lat_dout_ack", {16'd0, b_dout}, 32'd7);
      stepClock();
      checkOutput("lat_ack_single", {31'd0, b_ack_r}, 32'd0);
      checkOutput("lat_empty", {30'd0, b_level}, 32'd0);

      // Stream 0..999 through a full FIFO: push and pop coincide at level 3
      b_req_r = 1'b0;
      sent = 0;
      recv = 0;
      for (int c = 0; c < 6000 && recv < 1000; c++) begin
         if (b_req_l[0] && sent < 1000) begin
            b_ack_l = 1'b1;
            b_din   = 16'(sent);
            sent++;
         end else begin
            b_ack_l = 1'b0;
         end
         if (b_level == 2'd3) b_req_r = 1'b1;
         stepClock();
         if (b_ack_r[0]) begin
            checkOutput("stream_value", {16'd0, b_dout}, recv + 2);
            if (recv >= 1 && recv < 990) checkOutput("stream_level", {30'd0, b_level}, 32'd3);
            recv++;
         end
      end
      b_ack_l = 1'b0;
      checkOutput("stream_count", recv, 32'd1000);

      // Reset mid-operation with a held slot and a queued token
      applyStimulus(3'b111, {8'd3, 8'd3, 8'd3}, 3'b000);
      stepClock();
      applyStimulus(3'b000, 24'd0, 3'b000);
      stepClock();
      applyStimulus(3'b111, {8'd4, 8'd4, 8'd4}, 3'b000);
      stepClock();
      applyStimulus(3'b000, 24'd0, 3'b000);
      checkOutput("pre_rst_level", {30'd0, a_level}, 32'd1);
      checkOutput("pre_rst_held", {29'd0, a_req_l}, 32'd0);
      rst = 1'b1;
      stepClock();
      rst = 1'b0;
      applyStimulus(3'b000, 24'd0, 3'b111);
      checkOutput("rst_level", {30'd0, a_level}, 32'd0);
      checkOutput("rst_req_l", {29'd0, a_req_l}, 32'd0);
      checkOutput("rst_ack_r", {29'd0, a_ack_r}, 32'd0);
      checkOutput("rst_dout", {24'd0, a_dout}, 32'd0);
      stepClock();
      checkOutput("post_rst_req_l", {29'd0, a_req_l}, 32'd7);
      checkOutput("post_rst_no_ack", {29'd0, a_ack_r}, 32'd0);
      stepClock();
      checkOutput("post_rst_no_ack2", {29'd0, a_ack_r}, 32'd0);
      checkOutput("post_rst_empty", {30'd0, a_level}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
